bus_timer_bank: RTL and testbench
=================================

// Module: bus_timer_bank
// PURPOSE
//  N-channel programmable down-counter bank on the CPU memory bus; generalises the fixed 12e6 LED blinker.
//  Per channel: reload period, one-shot/periodic mode, toggle output, expiry flag and IRQ line.
//  Sits beside bus_reg/bus_uart. Its IRQs feed the CPU irq vector and its outputs drive LEDs.
//  Bus read outputs are zero when not selected, so they OR into the top-level bus_out.
// PARAMETERS
//  BUS_ADDR   32'h0400_0000  base byte address; channel c occupies BUS_ADDR + c*32
//  NCH        4              channel count, 1..16
//  WIDTH      24             counter/period width, 1..32; register reads zero-extend to 32 bits
//  PRESCALE   1              clk cycles per counter tick, >=1; one free-running prescaler shared by all channels
// PORTS
//  clk          in   1      single clock
//  reset        in   1      synchronous reset, active-high
//  bus_addr     in   32     byte address (CPU look-ahead address)
//  bus_wdata    in   32     write data
//  bus_be       in   4      byte enables for writes
//  bus_rd_req   in   1      read request, one-cycle pulse
//  bus_wr_req   in   1      write request, one-cycle pulse
//  bus_rd_data  out  32     read data; valid only with bus_rd_ack, else 0
//  bus_rd_ack   out  1      read acknowledge
//  bus_wr_ack   out  1      write acknowledge
//  irq          out  NCH    per-channel level IRQ = STATUS.exp & CTRL.irq_en
//  tmr_out      out  NCH    per-channel toggle (or PWM) output
// BEHAVIOUR
//  Register map (offset within channel):
//   +0x00 CTRL: [0] en, [1] oneshot, [2] irq_en, [3] pwm
//   +0x04 PERIOD
//   +0x08 COUNT, read-only
//   +0x0C STATUS: [0] exp, write-1-to-clear
//   +0x10 DUTY
//  Decode:
//   - Hit when addr[31:2] falls in an implemented word. Unimplemented offsets inside a stride read 0 and ignore writes, but still ack.
//   - Addresses outside BUS_ADDR..BUS_ADDR+NCH*32-1 give no ack; all bus outputs stay 0.
//  Handshake:
//   - ack asserted exactly 1 cycle after req, for 1 cycle; rd_data is registered and valid in that cycle.
//   - If rd_req and wr_req arrive together, the write is performed and only wr_ack is returned.
//  Writes honour bus_be per byte. Bits above WIDTH and unused CTRL bits are read as 0.
//  Counting:
//   - Tick = 1-cycle pulse every PRESCALE clks.
//   - en 0->1 write loads COUNT=PERIOD.
//   - On a tick with en=1: COUNT!=0 -> decrement. COUNT==0 -> set exp, toggle tmr_out, then reload PERIOD (periodic) or clear en (oneshot).
//   - PERIOD=0: expires every tick.
//   - PERIOD write while running takes effect at the next reload only.
//   - en=0 freezes COUNT.
//  Simultaneous events:
//   - W1C of exp and a new expiry in the same cycle: set wins, exp=1.
//   - CPU write to CTRL.en in the same cycle as a oneshot self-clear: the CPU write wins.
//  Reset, including mid-count: CTRL/PERIOD/COUNT/STATUS/DUTY=0, prescaler=0, tmr_out=0, irq=0, bus_rd_data=0, acks=0. Any in-flight request is dropped with no ack.
// CONFIGURATION
//  Macro BUS_TIMER_PWM_EN:
//   - Defined: DUTY is implemented (WIDTH bits). When CTRL.pwm=1, tmr_out = (COUNT < DUTY), registered, and the toggle is suppressed.
//   - Undefined: DUTY reads 0, writes are ignored, CTRL.pwm reads 0, tmr_out is always the toggle output, and no compare logic is built.
// STRUCTURE
//  Shared include bus_timer_params.v: register offsets, CTRL bit positions, channel stride (32).
//  Sub-module bus_timer_chan: one channel's registers, counter, flag and output, instanced NCH times via generate.
//  Top level holds the prescaler, address decode, ack/read-data pipeline register and read mux.
// TESTING
//  1 NCH=4, PRESCALE=1, PERIOD0=3, CTRL0=0x5 (en|irq_en): exp0 sets every 4 ticks; irq[0] rises 4 clks after enable; tmr_out[0] toggles each expiry.
//  2 CTRL1=0x3 (oneshot), PERIOD1=2: one expiry after 3 ticks; CTRL1 then reads 0x2; COUNT1 holds 0; no further toggles.
//  3 Write STATUS0=1 on the exact cycle exp0 re-sets -> STATUS0 reads 1. Write 1 in a quiet cycle -> reads 0 and irq[0] drops next cycle.
//  4 Bus: read BUS_ADDR+0x08 -> rd_ack 1 cycle later, others 0. Read BUS_ADDR+NCH*32 -> no ack for 8 cycles. Write with be=4'b0001 to PERIOD changes bits [7:0] only.
//  5 Assert reset mid-count with COUNT=0x1234 -> next cycle all registers, irq and tmr_out are 0; a pending rd_req gets no ack.
//  6 BUS_TIMER_PWM_EN defined, PERIOD=9, DUTY=3, pwm=1: tmr_out high 3 of every 10 ticks. Undefined: DUTY reads 0.

Source files
------------

// File: rtl/bus_timer_bank_pkg.sv
// bus_timer_bank_pkg: register word map, CTRL bit positions and channel
// stride shared by the timer bank top and its channel sub-module.
package bus_timer_bank_pkg;

  localparam int STRIDE = 32;

  localparam int C_EN      = 0;
  localparam int C_ONESHOT = 1;
  localparam int C_IRQEN   = 2;
  localparam int C_PWM     = 3;

  typedef enum logic [2:0] {
    R_CTRL   = 3'd0,
    R_PERIOD = 3'd1,
    R_COUNT  = 3'd2,
    R_STATUS = 3'd3,
    R_DUTY   = 3'd4
  } reg_e;

  function automatic logic [31:0] be_mask(
    input logic [3:0] be
  );
    return {{8{be[3]}}, {8{be[2]}},
            {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/bus_timer_bank_chan.sv
// bus_timer_bank_chan: one timer channel -- registers, down-counter,
// expiry flag, IRQ and toggle output (PWM compare under BUS_TIMER_PWM_EN).
module bus_timer_bank_chan
  import bus_timer_bank_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_tick,
  input  logic        i_wr,
  input  logic [2:0]  i_word,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_be,
  output logic [31:0] o_rdata,
  output logic        o_irq,
  output logic        o_tmr_out
);

  logic             r_en;
  logic             r_oneshot;
  logic             r_irq_en;
  logic             r_exp;
  logic             r_tmr;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_count;

  logic             w_pwm;
  logic             w_run;
  logic             w_fire;
  logic             w_load;
  logic             w_wr_ctrl;
  logic             w_wr_period;
  logic             w_wr_status;
  logic [31:0]      w_bmask;
  logic [31:0]      w_ctrl;
  logic [WIDTH-1:0] w_period_n;
  logic             w_unused;

  assign w_bmask = be_mask(i_be);
  assign w_unused = ^{i_wdata, w_bmask};

  assign w_run  = i_tick & r_en;
  assign w_fire = w_run & (r_count == '0);

  assign w_wr_ctrl = i_wr & (i_word == R_CTRL)
                   & i_be[0];
  assign w_wr_period = i_wr & (i_word == R_PERIOD)
                     & (|i_be);
  assign w_wr_status = i_wr & (i_word == R_STATUS)
                     & i_be[0] & i_wdata[0];

  // Only a 0->1 transition of en reloads; rewriting en=1 keeps counting.
  assign w_load = w_wr_ctrl & i_wdata[C_EN] & ~r_en;

  assign w_period_n =
      (r_period & ~w_bmask[WIDTH-1:0])
    | (i_wdata[WIDTH-1:0] & w_bmask[WIDTH-1:0]);

`ifdef BUS_TIMER_PWM_EN
  logic             r_pwm;
  logic [WIDTH-1:0] r_duty;
  logic             w_wr_duty;
  logic [WIDTH-1:0] w_duty_n;

  assign w_pwm = r_pwm;
  assign w_wr_duty = i_wr & (i_word == R_DUTY)
                   & (|i_be);
  assign w_duty_n =
      (r_duty & ~w_bmask[WIDTH-1:0])
    | (i_wdata[WIDTH-1:0] & w_bmask[WIDTH-1:0]);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pwm  <= 1'b0;
      r_duty <= '0;
    end else begin
      if (w_wr_ctrl)
        r_pwm <= i_wdata[C_PWM];
      if (w_wr_duty)
        r_duty <= w_duty_n;
    end
  end
`else
  assign w_pwm = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_en      <= 1'b0;
      r_oneshot <= 1'b0;
      r_irq_en  <= 1'b0;
      r_exp     <= 1'b0;
      r_tmr     <= 1'b0;
      r_period  <= '0;
      r_count   <= '0;
    end else begin
      // CPU write of en beats the oneshot self-clear.
      if (w_wr_ctrl) begin
        r_en      <= i_wdata[C_EN];
        r_oneshot <= i_wdata[C_ONESHOT];
        r_irq_en  <= i_wdata[C_IRQEN];
      end else if (w_fire & r_oneshot) begin
        r_en <= 1'b0;
      end
      if (w_wr_period)
        r_period <= w_period_n;
      if (w_load)
        r_count <= r_period;
      else if (w_fire)
        r_count <= r_oneshot ? r_count : r_period;
      else if (w_run)
        r_count <= r_count - WIDTH'(1);
      if (w_fire)
        r_exp <= 1'b1;
      else if (w_wr_status)
        r_exp <= 1'b0;
`ifdef BUS_TIMER_PWM_EN
      if (w_pwm)
        r_tmr <= (r_count < r_duty);
      else if (w_fire)
        r_tmr <= ~r_tmr;
`else
      if (w_fire)
        r_tmr <= ~r_tmr;
`endif
    end
  end

  always_comb begin
    w_ctrl = '0;
    w_ctrl[C_EN]      = r_en;
    w_ctrl[C_ONESHOT] = r_oneshot;
    w_ctrl[C_IRQEN]   = r_irq_en;
    w_ctrl[C_PWM]     = w_pwm;
  end

  always_comb begin
    o_rdata = '0;
    case (i_word)
      R_CTRL:   o_rdata = w_ctrl;
      R_PERIOD: o_rdata = 32'(r_period);
      R_COUNT:  o_rdata = 32'(r_count);
      R_STATUS: o_rdata[0] = r_exp;
`ifdef BUS_TIMER_PWM_EN
      R_DUTY:   o_rdata = 32'(r_duty);
`endif
      default:  o_rdata = '0;
    endcase
  end

  assign o_irq     = r_exp & r_irq_en;
  assign o_tmr_out = r_tmr;

endmodule

// File: rtl/bus_timer_bank.sv
// bus_timer_bank: NCH-channel bus-mapped down-counter bank with shared
// prescaler and registered acks. Optional PWM: define BUS_TIMER_PWM_EN.
module bus_timer_bank
  import bus_timer_bank_pkg::*;
#(
  parameter logic [31:0] BUS_ADDR = 32'h0400_0000,
  parameter int          NCH      = 4,
  parameter int          WIDTH    = 24,
  parameter int          PRESCALE = 1
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [31:0]    i_bus_addr,
  input  logic [31:0]    i_bus_wdata,
  input  logic [3:0]     i_bus_be,
  input  logic           i_bus_rd_req,
  input  logic           i_bus_wr_req,
  output logic [31:0]    o_bus_rd_data,
  output logic           o_bus_rd_ack,
  output logic           o_bus_wr_ack,
  output logic [NCH-1:0] o_irq,
  output logic [NCH-1:0] o_tmr_out
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0] r_presc;
  logic          r_rd_ack;
  logic          r_wr_ack;
  logic [31:0]   r_rd_data;

  logic          w_tick;
  logic [31:0]   w_off;
  logic          w_hit;
  logic [CW-1:0] w_ch;
  logic [2:0]    w_word;
  logic          w_rd;
  logic [31:0]   w_rdata [NCH];

  assign w_tick = (r_presc == PW'(PRESCALE - 1));

  // Wrap-around subtract: addresses below the base become huge and miss.
  assign w_off  = i_bus_addr - BUS_ADDR;
  assign w_hit  = (w_off < 32'(NCH * STRIDE));
  assign w_ch   = w_off[5 +: CW];
  assign w_word = w_off[4:2];
  assign w_rd   = i_bus_rd_req & ~i_bus_wr_req & w_hit;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    logic w_wr;
    assign w_wr = i_bus_wr_req & w_hit
                & (w_ch == CW'(c));
    bus_timer_bank_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_tick    (w_tick),
      .i_wr      (w_wr),
      .i_word    (w_word),
      .i_wdata   (i_bus_wdata),
      .i_be      (i_bus_be),
      .o_rdata   (w_rdata[c]),
      .o_irq     (o_irq[c]),
      .o_tmr_out (o_tmr_out[c])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_presc   <= '0;
      r_rd_ack  <= 1'b0;
      r_wr_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + PW'(1);
      r_wr_ack  <= i_bus_wr_req & w_hit;
      r_rd_ack  <= w_rd;
      r_rd_data <= w_rd ? w_rdata[w_ch] : '0;
    end
  end

  assign o_bus_rd_data = r_rd_data;
  assign o_bus_rd_ack  = r_rd_ack;
  assign o_bus_wr_ack  = r_wr_ack;

endmodule

// File: tb/tb_bus_timer_bank.sv
// tb_bus_timer_bank: directed + random bus traffic, scoreboard of acks and
// read data, per-cycle irq/tmr_out check against a behavioural model.
module tb_bus_timer_bank;

  localparam logic [31:0] BASE = 32'h0400_0000;
  localparam int NCH = 4;
  localparam int WIDTH = 24;
  localparam int PRESCALE = 1;
  localparam logic [31:0] M = (WIDTH >= 32) ? 32'hFFFF_FFFF
                            : 32'((64'd1 << WIDTH) - 64'd1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [31:0]    addr = '0;
  logic [31:0]    wdata = '0;
  logic [3:0]     be = '0;
  logic           rd_req = 1'b0;
  logic           wr_req = 1'b0;
  logic [31:0]    rd_data;
  logic           rd_ack;
  logic           wr_ack;
  logic [NCH-1:0] irq;
  logic [NCH-1:0] tmr_out;

  always #5 clk = ~clk;

  bus_timer_bank #(
    .BUS_ADDR (BASE),
    .NCH      (NCH),
    .WIDTH    (WIDTH),
    .PRESCALE (PRESCALE)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_bus_addr    (addr),
    .i_bus_wdata   (wdata),
    .i_bus_be      (be),
    .i_bus_rd_req  (rd_req),
    .i_bus_wr_req  (wr_req),
    .o_bus_rd_data (rd_data),
    .o_bus_rd_ack  (rd_ack),
    .o_bus_wr_ack  (wr_ack),
    .o_irq         (irq),
    .o_tmr_out     (tmr_out)
  );

  typedef struct {
    int          due;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;

  logic [31:0] m_period [NCH];
  logic [31:0] m_count  [NCH];
  logic [31:0] m_duty   [NCH];
  bit          m_en     [NCH];
  bit          m_os     [NCH];
  bit          m_ie     [NCH];
  bit          m_pwm    [NCH];
  bit          m_exp    [NCH];
  bit          m_tout   [NCH];
  int          m_clks = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] want);
    n_run++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, want, cyc);
    end
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old,
                                        logic [31:0] wd,
                                        logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (b[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r & M;
  endfunction

  function automatic logic [31:0] mread(int c, int w);
    case (w)
      0: return {28'd0, m_pwm[c], m_ie[c], m_os[c], m_en[c]};
      1: return m_period[c];
      2: return m_count[c];
      3: return {31'd0, m_exp[c]};
      4: return m_duty[c];
      default: return 32'd0;
    endcase
  endfunction

  // Model of one clock edge, using the inputs presented before it.
  task automatic model_edge();
    logic [31:0] off;
    int  ch;
    int  w;
    bit  hit;
    bit  tick;
    bit  fire [NCH];
    bit  pre_en [NCH];
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_period[c] = 0; m_count[c] = 0; m_duty[c] = 0;
        m_en[c] = 0; m_os[c] = 0; m_ie[c] = 0;
        m_pwm[c] = 0; m_exp[c] = 0; m_tout[c] = 0;
      end
      m_clks = 0;
      return;
    end
    tick = (m_clks % PRESCALE) == PRESCALE - 1;
    m_clks++;
    off = addr - BASE;
    hit = off < NCH * 32;
    ch  = int'(off / 32);
    w   = int'((off % 32) / 4);
    if (hit && rd_req && !wr_req)
      q.push_back('{cyc, 1'b1, mread(ch, w)});
    if (hit && wr_req)
      q.push_back('{cyc, 1'b0, 32'd0});
    for (int c = 0; c < NCH; c++) begin
      pre_en[c] = m_en[c];
      fire[c] = tick && m_en[c] && m_count[c] == 0;
      if (m_pwm[c])
        m_tout[c] = m_count[c] < m_duty[c];
      else if (fire[c])
        m_tout[c] = !m_tout[c];
      if (tick && m_en[c]) begin
        if (m_count[c] != 0) m_count[c] = m_count[c] - 1;
        else if (!m_os[c]) m_count[c] = m_period[c];
      end
      if (fire[c]) begin
        m_exp[c] = 1;
        if (m_os[c]) m_en[c] = 0;
      end
    end
    if (hit && wr_req) begin
      case (w)
        0: if (be[0]) begin
          if (wdata[0] && !pre_en[ch]) m_count[ch] = m_period[ch];
          m_en[ch] = wdata[0];
          m_os[ch] = wdata[1];
          m_ie[ch] = wdata[2];
`ifdef BUS_TIMER_PWM_EN
          m_pwm[ch] = wdata[3];
`endif
        end
        1: m_period[ch] = merge(m_period[ch], wdata, be);
        3: if (be[0] && wdata[0] && !fire[ch]) m_exp[ch] = 0;
`ifdef BUS_TIMER_PWM_EN
        4: m_duty[ch] = merge(m_duty[ch], wdata, be);
`endif
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin : mon
    bit          er;
    bit          ew;
    logic [31:0] ed;
    logic [NCH-1:0] ei;
    logic [NCH-1:0] et;
    if (mon_on) begin
      er = 0; ew = 0; ed = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        er = q[0].rd;
        ew = !q[0].rd;
        if (q[0].rd) ed = q[0].data;
        void'(q.pop_front());
      end
      for (int c = 0; c < NCH; c++) begin
        ei[c] = m_exp[c] & m_ie[c];
        et[c] = m_tout[c];
      end
      chk("rd_ack", 32'(rd_ack), 32'(er));
      chk("wr_ack", 32'(wr_ack), 32'(ew));
      chk("rd_data", rd_data, ed);
      chk("irq", 32'(irq), 32'(ei));
      chk("tmr_out", 32'(tmr_out), 32'(et));
    end
  end

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic bwr(logic [31:0] a, logic [31:0] d,
                     logic [3:0] b = 4'hF);
    addr = a; wdata = d; be = b; wr_req = 1;
    step();
    wr_req = 0; be = 0;
  endtask

  task automatic brd(logic [31:0] a);
    addr = a; rd_req = 1;
    step();
    rd_req = 0;
  endtask

  function automatic logic [31:0] ra(int c, int o);
    return BASE + 32'(c * 32 + o);
  endfunction

  task automatic bound_fail(string nm);
    n_run++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  initial begin
    int k;
    idle(2);
    mon_on = 1;
    rst = 0;
    idle(2);
    // periodic channel 0
    bwr(ra(0, 4), 3);
    bwr(ra(0, 0), 32'h5);
    idle(12);
    brd(ra(0, 12));
    // oneshot channel 1
    bwr(ra(1, 4), 2);
    bwr(ra(1, 0), 32'h3);
    idle(8);
    brd(ra(1, 0));
    brd(ra(1, 8));
    // W1C colliding with a new expiry
    k = 0;
    while (!(m_en[0] && m_count[0] == 0) && k < 50) begin
      step(); k++;
    end
    if (k >= 50) bound_fail("w1c_collide_wait");
    bwr(ra(0, 12), 1);
    brd(ra(0, 12));
    // W1C in a quiet cycle
    k = 0;
    while (!(m_count[0] == 2) && k < 50) begin
      step(); k++;
    end
    if (k >= 50) bound_fail("w1c_quiet_wait");
    bwr(ra(0, 12), 1);
    brd(ra(0, 12));
    idle(2);
    // bus decode and byte enables
    brd(ra(0, 8));
    brd(BASE + NCH * 32);
    brd(BASE - 4);
    idle(8);
    bwr(ra(2, 4), 32'hA5A5_A5A5, 4'b0001);
    brd(ra(2, 4));
    bwr(ra(2, 4), 32'h1234_5678, 4'b0110);
    brd(ra(2, 4));
    brd(ra(1, 20));
    bwr(ra(1, 28), 32'hFFFF_FFFF);
    addr = ra(3, 4); wdata = 7; be = 4'hF;
    rd_req = 1; wr_req = 1;
    step();
    rd_req = 0; wr_req = 0;
    brd(ra(3, 4));
`ifdef BUS_TIMER_PWM_EN
    bwr(ra(3, 4), 9);
    bwr(ra(3, 16), 3);
    bwr(ra(3, 0), 32'h9);
    idle(30);
    brd(ra(3, 16));
`else
    bwr(ra(3, 16), 5);
    brd(ra(3, 16));
    bwr(ra(3, 0), 32'h9);
    brd(ra(3, 0));
`endif
    // randomized traffic
    repeat (600) begin
      k = $urandom_range(0, 9);
      if ($urandom_range(0, 9) == 0)
        addr = BASE + 32'($urandom_range(NCH * 32 - 8, NCH * 32 + 8));
      else
        addr = ra($urandom_range(0, NCH - 1),
                  $urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      wdata = ($urandom_range(0, 3) == 0) ? $urandom
                                          : 32'($urandom_range(0, 7));
      be = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      rd_req = (k < 4) || (k == 8);
      wr_req = (k >= 4) && (k <= 8);
      rst = ($urandom_range(0, 199) == 0);
      step();
      rd_req = 0; wr_req = 0; rst = 0;
    end
    // reset mid-count with a pending read
    bwr(ra(2, 4), 32'h1240);
    bwr(ra(2, 0), 32'h5);
    idle(12);
    addr = ra(2, 8); rd_req = 1; rst = 1;
    step();
    rd_req = 0; rst = 0;
    for (int c = 0; c < NCH; c++)
      for (int o = 0; o < 20; o += 4)
        brd(ra(c, o));
    idle(3);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
